// File: rtl/video_pixel_serializer.sv
// Apple IIe multi-mode video serializer.
// Builds a 14-dot pattern per character cell for TEXT40, TEXT80, LORES, HIRES
// and DHIRES, shifts it out one dot per CLK_14M on VIDEO, owns the flash-rate
// counter and forms the addresses for the main and aux character ROMs.
module video_pixel_serializer #(
  parameter int CHAR_W       = 7,
  parameter int ROM_AW       = 12,
  parameter int FLASH_FRAMES = 16
) (
  input  logic              CLK_14M,
  input  logic              RESET,
  input  logic              PIX_CE,
  input  logic              LOAD_N,
  input  logic              WNDW_N,
  input  logic [2:0]        MODE,
  input  logic              ALTCHAR,
  input  logic              SEGA,
  input  logic              SEGB,
  input  logic              SEGC,
  input  logic              COL_ODD,
  input  logic [7:0]        DL_MAIN,
  input  logic [7:0]        DL_AUX,
  input  logic              VBL_TICK,
  output logic [ROM_AW-1:0] ROM_ADDR_M,
  output logic [ROM_AW-1:0] ROM_ADDR_A,
  input  logic [7:0]        ROM_Q_M,
  input  logic [7:0]        ROM_Q_A,
  output logic              FLASH,
  output logic              VIDEO
);

  localparam int PAT_W = 2 * CHAR_W;
  // Enough repeats of a LORES nibble to cover the pattern plus a 2-dot phase shift.
  localparam int REP_N = (PAT_W + 2 + 3) / 4;
  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [2:0] MODE_TEXT80 = 3'd1;
  localparam logic [2:0] MODE_LORES  = 3'd2;
  localparam logic [2:0] MODE_HIRES  = 3'd3;
  localparam logic [2:0] MODE_DHIRES = 3'd4;

  logic [PAT_W-1:0]   sr;
  logic               last_q;
  logic [CNT_W-1:0]   flash_cnt;
  logic [PAT_W-1:0]   load_pat;
  logic [PAT_W-1:0]   dbl_main;
  logic [PAT_W-1:0]   dbl_rom_m;
  logic [3:0]         lores_nib;
  logic [4*REP_N-1:0] lores_rep;
  logic [PAT_W-1:0]   lores_pat;
  logic               load;
  logic               unused_rom_msb;

  // Character ROM address: bit 10 selects inverse/flash, bit 9 the alternate
  // (MouseText) half; the top bit is the graphics-ROM select, held low.
  function automatic logic [11:0] char_addr(input logic [7:0] b,
                                            input logic       flash,
                                            input logic       alt,
                                            input logic [2:0] seg);
    logic a10;
    logic a9;
    a10 = b[7] | (b[6] & flash & ~alt & ~b[7]);
    a9  = b[6] & (alt | b[7]);
    return {1'b0, a10, a9, b[5:0], seg};
  endfunction

  assign ROM_ADDR_M = ROM_AW'(char_addr(DL_MAIN, FLASH, ALTCHAR, {SEGC, SEGB, SEGA}));
  assign ROM_ADDR_A = ROM_AW'(char_addr(DL_AUX,  FLASH, ALTCHAR, {SEGC, SEGB, SEGA}));

  // PIX_CE qualifies only the load strobe; shifting runs every CLK_14M.
  assign load = PIX_CE & ~LOAD_N;

  // Each source bit widened to two dots (40-column and HIRES dot width).
  for (genvar g = 0; g < CHAR_W; g++) begin : g_double
    assign dbl_main[2*g]    = DL_MAIN[g];
    assign dbl_main[2*g+1]  = DL_MAIN[g];
    assign dbl_rom_m[2*g]   = ~ROM_Q_M[g];
    assign dbl_rom_m[2*g+1] = ~ROM_Q_M[g];
  end

  // LORES colour nibble repeated across the cell; odd columns start two dots
  // later in the repeat so the colour phase stays continuous across cells.
  assign lores_nib = SEGC ? DL_MAIN[7:4] : DL_MAIN[3:0];
  assign lores_rep = {REP_N{lores_nib}};
  assign lores_pat = COL_ODD ? lores_rep[PAT_W+1:2] : lores_rep[PAT_W-1:0];

  // The ROM MSB carries no dot information.
  assign unused_rom_msb = ^{ROM_Q_M[7], ROM_Q_A[7]};

  // Select the cell pattern for the current mode; bit 0 is the first dot shown.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    load_pat = '0;
    if (!WNDW_N) begin
      case (MODE)
        MODE_TEXT80: load_pat = {~ROM_Q_M[CHAR_W-1:0], ~ROM_Q_A[CHAR_W-1:0]};
        MODE_LORES:  load_pat = lores_pat;
        MODE_HIRES:  load_pat = DL_MAIN[7] ? {dbl_main[PAT_W-2:0], last_q} : dbl_main;
        MODE_DHIRES: load_pat = {DL_MAIN[CHAR_W-1:0], DL_AUX[CHAR_W-1:0]};
        default:     load_pat = dbl_rom_m;
      endcase
    end
  end

  // Dot shifter: load a new cell or shift one dot, zero-filling past the cell.
  // The cell's mode is captured in the pattern at load, so a MODE change
  // mid-cell cannot disturb the cell already being shown.
  always_ff @(posedge CLK_14M) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of sr, independent of statement order.
    if (RESET) begin
      sr     <= '0;
      last_q <= 1'b0;
      VIDEO  <= 1'b0;
    end else begin
      last_q <= sr[0];
      VIDEO  <= sr[0];
      if (load) begin
        sr <= load_pat;
      end else begin
        sr <= {1'b0, sr[PAT_W-1:1]};
      end
    end
  end

  // Flash-rate divider: FLASH toggles once every FLASH_FRAMES frame ticks.
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      flash_cnt <= '0;
      FLASH     <= 1'b0;
    end else if (VBL_TICK) begin
      if (flash_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
        flash_cnt <= '0;
        FLASH     <= ~FLASH;
      end else begin
        flash_cnt <= flash_cnt + CNT_W'(1);
      end
    end
  end

endmodule
